// File: rtl/sensor_pulse_gen.sv
// Speed-gate emulator: turns a commanded speed into a sensor_a / sensor_b pulse pair
// spaced T = floor(K / speed_kmh) clock ticks apart, T found by a restoring divider.
`timescale 1ns/1ps
module sensor_pulse_gen #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int DIST_MM = 100,
    parameter int PULSE_W = 1,
    parameter int MAX_KMH = 9999,
    parameter int QW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [13:0]   speed_kmh,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [QW-1:0] period_ticks,
    output logic          sensor_a,
    output logic          sensor_b
);

    // K needs 64-bit elaboration math: the default product overflows 32 bits before the divide
    localparam logic [63:0]    K_FULL  = 64'(DIST_MM) * 64'(CLK_HZ) * 64'd36 / 64'd10000;
    localparam logic [QW-1:0]  K       = K_FULL[QW-1:0];
    localparam int             IDX_W   = $clog2(QW);
    localparam logic [14:0]    MAX_V   = 15'(MAX_KMH);
    localparam logic [QW-1:0]  PW_LAST = QW'(PULSE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIV,
        S_PULSE_A,
        S_WAIT,
        S_PULSE_B,
        S_FIN
    } state_t;

    typedef struct packed {
        logic        q_bit;
        logic [13:0] rem;
    } div_step_t;

    // One restoring-division step; rem < dvsr on entry keeps the result inside 14 bits
    function automatic div_step_t div_step(input logic [13:0] rem,
                                           input logic        k_bit,
                                           input logic [13:0] dvsr);
        logic [14:0] shifted;
        div_step_t   r;
        shifted = {rem, k_bit};
        if (shifted >= {1'b0, dvsr}) begin
            r.q_bit = 1'b1;
            r.rem   = 14'(shifted - {1'b0, dvsr});
        end else begin
            r.q_bit = 1'b0;
            r.rem   = shifted[13:0];
        end
        return r;
    endfunction

    state_t              state;
    logic [IDX_W-1:0]    bit_idx;
    logic [QW-1:0]       cnt;
    logic [13:0]         speed_q;
    logic [13:0]         rem_q;
    logic [QW-1:0]       quo_q;
    div_step_t           step;
    logic                speed_bad;

    assign step      = div_step(rem_q, K[bit_idx], speed_q);
    assign speed_bad = (speed_q == 14'd0) || ({1'b0, speed_q} > MAX_V);

    // Divider datapath: no reset needed, every sequence reloads it before use
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            speed_q <= speed_kmh;
        end
        if (state == S_CHECK) begin
            rem_q <= '0;
            quo_q <= '0;
        end else if (state == S_DIV) begin
            rem_q <= step.rem;
            quo_q <= {quo_q[QW-2:0], step.q_bit};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            bit_idx      <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            period_ticks <= '0;
            sensor_a     <= 1'b0;
            sensor_b     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        err   <= 1'b0;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (speed_bad) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        bit_idx <= IDX_W'(QW - 1);
                        state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    // sensor_a rises on the same edge that retires the last quotient bit
                    if (bit_idx == '0) begin
                        sensor_a <= 1'b1;
                        cnt      <= '0;
                        state    <= S_PULSE_A;
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end
                S_PULSE_A: begin
                    cnt <= cnt + QW'(1);
                    if (cnt == PW_LAST) begin
                        sensor_a <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt holds ticks elapsed since A0, so b rises exactly at A0+T
                    if (cnt == quo_q - QW'(1)) begin
                        sensor_b <= 1'b1;
                        cnt      <= '0;
                        state    <= S_PULSE_B;
                    end else begin
                        cnt <= cnt + QW'(1);
                    end
                end
                S_PULSE_B: begin
                    if (cnt == PW_LAST) begin
                        sensor_b     <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        period_ticks <= quo_q;
                        state        <= S_FIN;
                    end else begin
                        cnt <= cnt + QW'(1);
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_pulse_gen.sv
// Directed bench for sensor_pulse_gen, run with a scaled gate spacing (K = 432000) to keep runs short.
`timescale 1ns/1ps
module tb_sensor_pulse_gen;

    localparam int QW  = 32;
    localparam int PW  = 2;
    localparam int LAT = 2 + QW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [13:0]   speed_kmh;
    logic          busy;
    logic          done;
    logic          err;
    logic [QW-1:0] period_ticks;
    logic          sensor_a;
    logic          sensor_b;

    int total;
    int bad;

    sensor_pulse_gen #(
        .CLK_HZ (12_000_000),
        .DIST_MM(10),
        .PULSE_W(PW),
        .MAX_KMH(9999),
        .QW     (QW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .speed_kmh   (speed_kmh),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .period_ticks(period_ticks),
        .sensor_a    (sensor_a),
        .sensor_b    (sensor_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [13:0] spd;
        logic        exp_err;
        int          exp_t;
    } vec_t;

    vec_t vecs[8];

    // Called at a negedge with the DUT idle. Runs one sequence and checks it end to end.
    task automatic run_seq(input string tag, input logic [13:0] spd, input logic exp_err,
                           input int exp_t, input int inject_at);
        int a_rise, b_rise, a_w, b_w, done_k, busy_falls, ovl, k, budget, idle_busy;
        logic [QW-1:0] pt_before;
        logic prev_busy, err_at_done, busy_at_done;
        logic [QW-1:0] pt_at_done;
        a_rise = -1; b_rise = -1; a_w = 0; b_w = 0; done_k = -1;
        busy_falls = 0; ovl = 0; idle_busy = 0;
        err_at_done = 1'b0; busy_at_done = 1'b1; pt_at_done = '0;
        budget = exp_err ? 50 : exp_t + LAT + PW + 50;
        pt_before = period_ticks;
        speed_kmh = spd;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        speed_kmh = 14'd7;
        k = 1;
        chk($sformatf("%s_busy_after_start", tag), busy, 1);
        prev_busy = busy;
        while (done_k < 0 && k < budget) begin
            if (sensor_a) begin if (a_rise < 0) a_rise = k; a_w++; end
            if (sensor_b) begin if (b_rise < 0) b_rise = k; b_w++; end
            if (sensor_a && sensor_b) ovl++;
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
            if (done) begin
                done_k = k;
                err_at_done = err;
                busy_at_done = busy;
                pt_at_done = period_ticks;
            end else begin
                if (inject_at > 0 && k == inject_at) begin
                    start = 1'b1;
                    speed_kmh = 14'd50;
                end
                if (inject_at > 0 && k == inject_at + 1) start = 1'b0;
                @(negedge clk);
                k++;
            end
        end
        chk($sformatf("%s_done_cycle", tag), done_k, exp_err ? 2 : LAT + exp_t + PW);
        chk($sformatf("%s_err", tag), err_at_done, exp_err);
        chk($sformatf("%s_busy_at_done", tag), busy_at_done, 0);
        chk($sformatf("%s_period", tag), pt_at_done, exp_err ? pt_before : QW'(exp_t));
        if (exp_err) begin
            chk($sformatf("%s_a_count", tag), a_w, 0);
            chk($sformatf("%s_b_count", tag), b_w, 0);
        end else begin
            chk($sformatf("%s_a_rise", tag), a_rise, LAT);
            chk($sformatf("%s_b_gap", tag), b_rise - a_rise, exp_t);
            chk($sformatf("%s_a_width", tag), a_w, PW);
            chk($sformatf("%s_b_width", tag), b_w, PW);
        end
        chk($sformatf("%s_overlap", tag), ovl, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy || done || sensor_a || sensor_b) idle_busy++;
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
        end
        chk($sformatf("%s_idle_after", tag), idle_busy, 0);
        chk($sformatf("%s_busy_falls", tag), busy_falls, 1);
        chk($sformatf("%s_err_sticky", tag), err, exp_err);
    endtask

    initial begin
        int activity, k, kd1, a2, d2, a1;
        total = 0;
        bad = 0;
        rst = 1'b0;
        start = 1'b0;
        speed_kmh = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_period", period_ticks, 0);
        chk("rst_sensor_a", sensor_a, 0);
        chk("rst_sensor_b", sensor_b, 0);
        rst = 1'b1;
        @(negedge clk);

        // K = 10*12e6*36/10000 = 432000
        vecs[0] = '{14'd32,    1'b0, 13500};
        vecs[1] = '{14'd100,   1'b0, 4320};
        vecs[2] = '{14'd9999,  1'b0, 43};
        vecs[3] = '{14'd0,     1'b1, 0};
        vecs[4] = '{14'd10000, 1'b1, 0};
        vecs[5] = '{14'd4321,  1'b0, 99};
        vecs[6] = '{14'd16383, 1'b1, 0};
        vecs[7] = '{14'd1000,  1'b0, 432};
        for (int i = 0; i < 8; i++) begin
            run_seq($sformatf("vec%0d", i), vecs[i].spd, vecs[i].exp_err, vecs[i].exp_t, 0);
        end

        // start (speed 50) during WAIT is ignored
        run_seq("ignored_start", 14'd32, 1'b0, 13500, LAT + PW + 500);

        // Reset in the middle of WAIT
        speed_kmh = 14'd32;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LAT + PW + 999) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_period", period_ticks, 0);
        chk("midrst_sensors", {sensor_a, sensor_b, done, err}, 0);
        activity = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy || done || sensor_a || sensor_b) activity++;
        end
        chk("midrst_quiet", activity, 0);
        rst = 1'b1;
        @(negedge clk);
        run_seq("post_rst", 14'd32, 1'b0, 13500, 0);

        // start held high: back-to-back sequences at speed 9999 (T = 43)
        speed_kmh = 14'd9999;
        start = 1'b1;
        kd1 = -1; a1 = -1; a2 = -1; d2 = -1;
        k = 0;
        while (d2 < 0 && k < 300) begin
            @(negedge clk);
            k++;
            if (sensor_a && a1 < 0) a1 = k;
            if (kd1 > 0 && k == kd1 + 1) chk("b2b_idle_busy", busy, 0);
            if (kd1 > 0 && k == kd1 + 2) begin
                chk("b2b_restart_busy", busy, 1);
                start = 1'b0;
            end
            if (kd1 > 0 && sensor_a && a2 < 0) a2 = k;
            if (done) begin
                if (kd1 < 0) kd1 = k;
                else d2 = k;
            end
        end
        start = 1'b0;
        chk("b2b_first_a", a1, LAT);
        chk("b2b_first_done", kd1, LAT + 43 + PW);
        chk("b2b_second_a", a2, kd1 + 1 + LAT);
        chk("b2b_second_done", d2, kd1 + 1 + LAT + 43 + PW);
        chk("b2b_period", period_ticks, 43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
